// File: rtl/pattern_gen_if.sv
// Handshake and configuration bundle for pattern_gen: the master side drives the
// generator controls and the sink ready, the slave side (the generator) returns the words.
interface pattern_gen_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 8
);
  logic                  enable;
  logic                  start;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] step;
  logic [DATA_WIDTH-1:0] limit;
  logic [DATA_WIDTH-1:0] seed;
  logic [LEN_W-1:0]      burst_len;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  busy;
  logic                  done;

  modport master (
    output enable, start, mode, step, limit, seed, burst_len, out_ready,
    input  out_data, out_valid, busy, done
  );

  modport slave (
    input  enable, start, mode, step, limit, seed, burst_len, out_ready,
    output out_data, out_valid, busy, done
  );
endinterface

// File: rtl/pattern_gen.sv
// Burst pattern generator (arithmetic step, Galois LFSR, Gray count, constant) with a
// valid/ready output. Define PATGEN_WRAPCNT_EN to add the saturating wrap_cnt output.
module pattern_gen #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    LEN_W      = 8,
  parameter logic [DATA_WIDTH-1:0] POLY       = 16'hB400,
  parameter int                    CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  pattern_gen_if.slave     bus
`ifdef PATGEN_WRAPCNT_EN
  ,
  output logic [CNT_W-1:0] wrap_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ARITH = 2'b00;
  localparam logic [1:0] MODE_LFSR  = 2'b01;
  localparam logic [1:0] MODE_GRAY  = 2'b10;
  localparam logic [1:0] MODE_CONST = 2'b11;

  localparam logic [DATA_WIDTH-1:0] ONE_D = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_W:0]        ONE_L = {{LEN_W{1'b0}}, 1'b1};

  if (DATA_WIDTH < 2) begin : g_bad_data_width
    $error("pattern_gen: DATA_WIDTH must be at least 2");
  end
  if (LEN_W < 1) begin : g_bad_len_w
    $error("pattern_gen: LEN_W must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pattern_gen: CNT_W must be at least 1");
  end

  function automatic logic [DATA_WIDTH-1:0] gray_of(input logic [DATA_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed starts from 1.
  function automatic logic [DATA_WIDTH-1:0] first_word(input logic [1:0]            m,
                                                       input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    if (m == MODE_LFSR) w = (s == '0) ? ONE_D : s;
    return w;
  endfunction

  // The sum is formed one bit wider so a carry out also counts as exceeding limit.
  function automatic logic arith_wraps(input logic [DATA_WIDTH-1:0] acc,
                                       input logic [DATA_WIDTH-1:0] stp,
                                       input logic [DATA_WIDTH-1:0] lim);
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, acc} + {1'b0, stp};
    return sum > {1'b0, lim};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] next_word(input logic [1:0]            m,
                                                      input logic [DATA_WIDTH-1:0] acc,
                                                      input logic [DATA_WIDTH-1:0] stp,
                                                      input logic [DATA_WIDTH-1:0] lim);
    logic [DATA_WIDTH-1:0] w;
    w = acc;
    case (m)
      MODE_ARITH: w = arith_wraps(acc, stp, lim) ? '0 : acc + stp;
      MODE_LFSR:  w = (acc >> 1) ^ (acc[0] ? POLY : '0);
      MODE_GRAY:  w = (acc == lim) ? '0 : acc + ONE_D;
      default:    w = acc;
    endcase
    return w;
  endfunction

  state_t                state_q, state_d;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] step_q;
  logic [DATA_WIDTH-1:0] limit_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [LEN_W-1:0]      len_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [LEN_W-1:0]      bcnt_q;
  logic [LEN_W:0]        bcnt_inc;
  logic                  accept;
  logic                  xfer;
  logic                  last_xfer;

  assign accept    = (state_q == IDLE) && bus.enable && bus.start;
  assign xfer      = (state_q == RUN) && bus.enable && bus.out_ready;
  assign bcnt_inc  = {1'b0, bcnt_q} + ONE_L;
  assign last_xfer = xfer && (len_q != '0) && (bcnt_inc == {1'b0, len_q});

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // enable low overrides every transition, including a start in the same cycle.
  always_comb begin
    state_d       = state_q;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        if (last_xfer) state_d = DONE;
      end
      DONE: begin
        bus.done = bus.enable;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!bus.enable) state_d = IDLE;
  end

  // Shadow registers hold the burst configuration; acc is the generator state.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mode_q  <= '0;
      step_q  <= '0;
      limit_q <= '0;
      seed_q  <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      bcnt_q  <= '0;
    end else if (!bus.enable) begin
      acc_q  <= '0;
      bcnt_q <= '0;
    end else if (accept) begin
      mode_q  <= bus.mode;
      step_q  <= bus.step;
      limit_q <= bus.limit;
      seed_q  <= bus.seed;
      len_q   <= bus.burst_len;
      acc_q   <= first_word(bus.mode, bus.seed);
      bcnt_q  <= '0;
    end else if (xfer) begin
      acc_q  <= next_word(mode_q, acc_q, step_q, limit_q);
      bcnt_q <= bcnt_inc[LEN_W-1:0];
    end
  end

  always_comb begin
    bus.out_data = '0;
    if (state_q == RUN) begin
      case (mode_q)
        MODE_GRAY:  bus.out_data = gray_of(acc_q);
        MODE_CONST: bus.out_data = seed_q;
        default:    bus.out_data = acc_q;
      endcase
    end
  end

`ifdef PATGEN_WRAPCNT_EN
  function automatic logic is_wrap(input logic [1:0]            m,
                                   input logic [DATA_WIDTH-1:0] acc,
                                   input logic [DATA_WIDTH-1:0] stp,
                                   input logic [DATA_WIDTH-1:0] lim);
    logic w;
    w = 1'b0;
    case (m)
      MODE_ARITH: w = arith_wraps(acc, stp, lim);
      MODE_GRAY:  w = (acc == lim);
      default:    w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [CNT_W-1:0] wrap_cnt_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                                           wrap_cnt_q <= '0;
    else if (accept)                                      wrap_cnt_q <= '0;
    else if (xfer && is_wrap(mode_q, acc_q, step_q, limit_q)) wrap_cnt_q <= sat_inc(wrap_cnt_q);
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: directed scenarios plus randomized bursts checked against a
// sequence model built directly from the generator's arithmetic rules.
module tb_pattern_gen;
  localparam int DW = 16;
  localparam int LW = 8;
  localparam int CW = 8;
  localparam logic [DW-1:0] POLY = 16'hB400;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  pattern_gen_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();
`ifdef PATGEN_WRAPCNT_EN
  logic [CW-1:0] wrap_cnt;
`endif

  pattern_gen #(.DATA_WIDTH(DW), .LEN_W(LW), .POLY(POLY), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
`ifdef PATGEN_WRAPCNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Word number idx of a burst, computed from the mode rules.
  function automatic logic [DW-1:0] model_word(input logic [1:0] m, input logic [DW-1:0] st,
                                               input logic [DW-1:0] lim, input logic [DW-1:0] sd,
                                               input int idx);
    int v;
    logic [DW-1:0] r;
    r = sd;
    case (m)
      2'b00: begin
        v = 0;
        for (int i = 0; i < idx; i++) begin
          v = v + int'(st);
          if (v > int'(lim)) v = 0;
        end
        r = v[DW-1:0];
      end
      2'b01: begin
        r = (sd == '0) ? 16'h0001 : sd;
        for (int i = 0; i < idx; i++) r = (r >> 1) ^ (r[0] ? POLY : 16'h0000);
      end
      2'b10: begin
        v = idx % (int'(lim) + 1);
        r = v[DW-1:0];
        r = r ^ (r >> 1);
      end
      default: r = sd;
    endcase
    return r;
  endfunction

`ifdef PATGEN_WRAPCNT_EN
  function automatic int model_wraps(input logic [1:0] m, input logic [DW-1:0] st,
                                     input logic [DW-1:0] lim, input int n);
    int v, w;
    v = 0;
    w = 0;
    for (int i = 0; i < n; i++) begin
      if (m == 2'b00) begin
        if (v + int'(st) > int'(lim)) begin w++; v = 0; end
        else v = v + int'(st);
      end else if (m == 2'b10) begin
        if (i % (int'(lim) + 1) == int'(lim)) w++;
      end
    end
    return (w > 255) ? 255 : w;
  endfunction
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [DW-1:0] st, input logic [DW-1:0] lim,
                          input logic [DW-1:0] sd, input logic [LW-1:0] len);
    bus.mode      = m;
    bus.step      = st;
    bus.limit     = lim;
    bus.seed      = sd;
    bus.burst_len = len;
    bus.enable    = 1'b1;
    bus.start     = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic force_idle();
    bus.start  = 1'b0;
    bus.enable = 1'b0;
    cyc();
    bus.enable = 1'b1;
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.start = 1'b1; bus.out_ready = 1'b1;
    bus.mode = 2'b11; bus.step = 16'd1; bus.limit = 16'd9; bus.seed = 16'hABCD; bus.burst_len = 8'd4;
    repeat (3) cyc();
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.out_valid, bus.busy, bus.done});
    end
    n_checks++;
    if (bus.out_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data: got %h want 0000", bus.out_data);
    end
`ifdef PATGEN_WRAPCNT_EN
    n_checks++;
    if (wrap_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_wrap_cnt: got %0d want 0", wrap_cnt);
    end
`endif
    bus.start = 1'b0;
    rst_l = 1'b1;
    cyc();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_idle: got valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_arith_vector();
    logic [DW-1:0] exp_w [6] = '{16'd0, 16'd73, 16'd146, 16'd219, 16'd292, 16'd0};
    bus.out_ready = 1'b1;
    do_start(2'b00, 16'd73, 16'd300, 16'd0, 8'd6);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({bus.out_valid, bus.busy, bus.done, bus.out_data} !== {3'b110, exp_w[i]}) begin
        n_fail++; $display("FAIL arith_word%0d: got v%b b%b d%b %0d want v1 b1 d0 %0d",
                           i, bus.out_valid, bus.busy, bus.done, bus.out_data, exp_w[i]);
      end
      cyc();
    end
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.done} !== 3'b001) begin
      n_fail++; $display("FAIL arith_done: got %b want 001", {bus.out_valid, bus.busy, bus.done});
    end
`ifdef PATGEN_WRAPCNT_EN
    n_checks++;
    if (wrap_cnt !== 8'd1) begin
      n_fail++; $display("FAIL arith_wrap_cnt: got %0d want 1", wrap_cnt);
    end
`endif
    cyc();
    n_checks++;
    if ({bus.out_valid, bus.done, bus.out_data} !== {2'b00, 16'h0000}) begin
      n_fail++; $display("FAIL arith_idle: got v%b d%b %h want v0 d0 0000", bus.out_valid, bus.done, bus.out_data);
    end
  endtask

  task automatic test_lfsr_seed0();
    logic [DW-1:0] exp_w [3] = '{16'h0001, 16'hB400, 16'h5A00};
    bus.out_ready = 1'b1;
    do_start(2'b01, 16'd0, 16'd0, 16'h0000, 8'd3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.out_data !== exp_w[i]) begin
        n_fail++; $display("FAIL lfsr_word%0d: got %h want %h", i, bus.out_data, exp_w[i]);
      end
      cyc();
    end
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++; $display("FAIL lfsr_done: got %b want 1", bus.done);
    end
    cyc();
  endtask

  task automatic test_gray_unbounded();
    logic [DW-1:0] pat [4] = '{16'd0, 16'd1, 16'd3, 16'd2};
    bus.out_ready = 1'b1;
    do_start(2'b10, 16'd0, 16'd3, 16'd0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({bus.out_valid, bus.done, bus.out_data} !== {2'b10, pat[i % 4]}) begin
        n_fail++; $display("FAIL gray_word%0d: got v%b d%b %0d want v1 d0 %0d",
                           i, bus.out_valid, bus.done, bus.out_data, pat[i % 4]);
      end
      cyc();
    end
    bus.enable = 1'b0;
    cyc();
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.done, bus.out_data} !== 19'd0) begin
      n_fail++; $display("FAIL gray_disable: got v%b b%b d%b %h want all 0",
                         bus.out_valid, bus.busy, bus.done, bus.out_data);
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    do_start(2'b00, 16'd73, 16'd300, 16'd0, 8'd4);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, 16'd0}) begin
        n_fail++; $display("FAIL stall_hold%0d: got v%b %0d want v1 0", i, bus.out_valid, bus.out_data);
      end
      cyc();
    end
    bus.out_ready = 1'b1;
    n_checks++;
    if (bus.out_data !== 16'd0) begin
      n_fail++; $display("FAIL stall_release: got %0d want 0", bus.out_data);
    end
    cyc();
    n_checks++;
    if (bus.out_data !== 16'd73) begin
      n_fail++; $display("FAIL stall_next: got %0d want 73", bus.out_data);
    end
    force_idle();
  endtask

  task automatic test_enable_abort();
    bus.out_ready = 1'b1;
    do_start(2'b00, 16'd5, 16'd1000, 16'd0, 8'd10);
    repeat (3) cyc();
    bus.enable = 1'b0;
    bus.start  = 1'b1;
    cyc();
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.done, bus.out_data} !== 19'd0) begin
      n_fail++; $display("FAIL abort_idle: got v%b b%b d%b %h want all 0",
                         bus.out_valid, bus.busy, bus.done, bus.out_data);
    end
    bus.start  = 1'b0;
    bus.enable = 1'b1;
    cyc();
    n_checks++;
    if ({bus.out_valid, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL abort_stays_idle: got v%b d%b want v0 d0", bus.out_valid, bus.done);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit seen_done;
    bus.out_ready = 1'b1;
    do_start(2'b00, 16'd5, 16'd1000, 16'd0, 8'd4);
    cyc();
    #2;
    rst_l = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.done, bus.out_data} !== 19'd0) begin
      n_fail++; $display("FAIL async_reset: got v%b b%b d%b %h want all 0",
                         bus.out_valid, bus.busy, bus.done, bus.out_data);
    end
`ifdef PATGEN_WRAPCNT_EN
    n_checks++;
    if (wrap_cnt !== 8'd0) begin
      n_fail++; $display("FAIL async_reset_wrap_cnt: got %0d want 0", wrap_cnt);
    end
`endif
    repeat (2) cyc();
    rst_l = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) begin
      n_fail++; $display("FAIL reset_no_resume: got activity after release want none");
    end
  endtask

  task automatic test_start_in_run_done();
    bus.out_ready = 1'b1;
    do_start(2'b00, 16'd1, 16'd1000, 16'd0, 8'd3);
    bus.start = 1'b1;
    bus.mode  = 2'b11;
    bus.seed  = 16'hC0DE;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.out_data !== 16'(i)) begin
        n_fail++; $display("FAIL shadow_word%0d: got %0d want %0d", i, bus.out_data, i);
      end
      cyc();
    end
    n_checks++;
    if ({bus.out_valid, bus.done} !== 2'b01) begin
      n_fail++; $display("FAIL start_in_run_done: got v%b d%b want v0 d1", bus.out_valid, bus.done);
    end
    cyc();
    n_checks++;
    if ({bus.out_valid, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL start_ignored_done: got v%b d%b want v0 d0", bus.out_valid, bus.done);
    end
    cyc();
    n_checks++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 16'hC0DE}) begin
      n_fail++; $display("FAIL restart_const: got v%b %h want v1 c0de", bus.out_valid, bus.out_data);
    end
    force_idle();
  endtask

  task automatic test_random_bursts();
    logic [1:0]    m;
    logic [DW-1:0] st, lim, sd, expw;
    int            len, k;
    bit            fin, rdy;
    for (int b = 0; b < 16; b++) begin
      m   = 2'($urandom_range(0, 3));
      st  = DW'($urandom_range(0, 600));
      lim = (m == 2'b10) ? DW'($urandom_range(0, 15)) : DW'($urandom_range(0, 2000));
      sd  = DW'($urandom);
      len = $urandom_range(1, 12);
      bus.out_ready = 1'b0;
      do_start(m, st, lim, sd, LW'(len));
      k   = 0;
      fin = 1'b0;
      for (int c = 0; c < 300 && !fin; c++) begin
        if (k == len) begin
          n_checks++;
          if ({bus.out_valid, bus.busy, bus.done} !== 3'b001) begin
            n_fail++; $display("FAIL rand%0d_done: got %b want 001", b, {bus.out_valid, bus.busy, bus.done});
          end
`ifdef PATGEN_WRAPCNT_EN
          n_checks++;
          if (int'(wrap_cnt) != model_wraps(m, st, lim, len)) begin
            n_fail++; $display("FAIL rand%0d_wrap_cnt: got %0d want %0d", b, wrap_cnt, model_wraps(m, st, lim, len));
          end
`endif
          fin = 1'b1;
        end else begin
          expw = model_word(m, st, lim, sd, k);
          n_checks++;
          if ({bus.out_valid, bus.out_data} !== {1'b1, expw}) begin
            n_fail++; $display("FAIL rand%0d_word%0d mode%0d: got v%b %h want v1 %h",
                               b, k, m, bus.out_valid, bus.out_data, expw);
          end
          rdy = 1'($urandom_range(0, 1));
          bus.out_ready = rdy;
          bus.start     = 1'($urandom_range(0, 1));
          bus.mode      = 2'($urandom_range(0, 3));
          bus.step      = DW'($urandom);
          bus.limit     = DW'($urandom);
          bus.seed      = DW'($urandom);
          bus.burst_len = LW'($urandom);
          if (rdy) k++;
          cyc();
        end
      end
      if (!fin) begin
        n_checks++; n_fail++;
        $display("FAIL rand%0d_timeout: got %0d transfers want %0d", b, k, len);
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
      force_idle();
    end
  endtask

  initial begin
    bus.enable = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b0;
    bus.mode = 2'b00; bus.step = '0; bus.limit = '0; bus.seed = '0; bus.burst_len = '0;
    test_reset();
    test_arith_vector();
    test_lfsr_seed0();
    test_gray_unbounded();
    test_backpressure();
    test_enable_abort();
    test_reset_mid_burst();
    test_start_in_run_done();
    test_random_bursts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of generated words and of step/limit/seed.
REQ-002 Parameter LEN_W, default 8, SHALL set the width of burst_len.
REQ-003 Parameter POLY, default 16'hB400, SHALL be the Galois LFSR feedback mask, DATA_WIDTH bits.
REQ-004 Parameter CNT_W, default 8, SHALL set the width of wrap_cnt.
REQ-005 clk  input  1  rising-edge clock; rst_l  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  level; low forces generator idle and cleared.
REQ-007 start  input  1  start request, accepted only in IDLE with enable high.
REQ-008 mode  input  2  00 arithmetic step, 01 LFSR, 10 Gray count, 11 constant seed.
REQ-009 step, limit, seed  input  DATA_WIDTH each  increment, inclusive upper bound, LFSR/constant value.
REQ-010 burst_len  input  LEN_W  words per burst; 0 = unbounded.
REQ-011 out_ready  input  1  sink ready.
REQ-012 out_data  output  DATA_WIDTH  generated word; out_valid  output  1  word valid.
REQ-013 busy  output  1  high in RUN; done  output  1  one-cycle end-of-burst pulse.
REQ-014 wrap_cnt  output  CNT_W  wrap counter, present only with PATGEN_WRAPCNT_EN.

Function
REQ-015 FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on accepted start, RUN->DONE after last burst transfer, DONE->IDLE unconditionally next cycle.
REQ-016 On start accept, mode/step/limit/seed/burst_len SHALL be captured into shadow registers; input changes during RUN SHALL have no effect.
REQ-017 out_valid SHALL be high exactly in RUN; first word SHALL be valid the cycle after the start-accept edge.
REQ-018 A transfer occurs when out_valid and out_ready are both high; the generator SHALL advance only on a transfer, and out_data SHALL stay stable while out_valid high and out_ready low.
REQ-019 Mode 00: first word 0; next = acc+step evaluated in DATA_WIDTH+1 bits; if that sum > limit, next = 0 (wrap), so no emitted word exceeds limit.
REQ-020 Mode 01: first word seed, or 1 if seed is 0; next = (acc>>1) XOR (acc[0] ? POLY : 0); limit ignored.
REQ-021 Mode 10: internal binary count starts at 0, increments by 1, wraps to 0 after value limit; out_data = bin XOR (bin>>1).
REQ-022 Mode 11: out_data SHALL equal the captured seed on every transfer.
REQ-023 Burst counter SHALL count transfers; at the transfer making count == burst_len (nonzero), FSM SHALL enter DONE with out_valid low the next cycle.
REQ-024 burst_len 0 SHALL run until enable deasserts; done never pulses.
REQ-025 done SHALL be high only in DONE; start in RUN or DONE SHALL be ignored.
REQ-026 enable low SHALL move any state to IDLE at next edge, clear acc and burst counter, and suppress done; enable low wins over simultaneous start.
REQ-027 In IDLE out_data SHALL read 0.

Reset
REQ-028 rst_l low SHALL asynchronously force IDLE, out_data 0, out_valid 0, busy 0, done 0, all counters and shadow registers 0.
REQ-029 Reset mid-burst SHALL abort without a done pulse; operation resumes only on a new start after release.

Configuration
REQ-030 With PATGEN_WRAPCNT_EN defined, wrap_cnt SHALL count wraps (modes 00, 10), saturate at all-ones, clear on start accept and reset.
REQ-031 Without PATGEN_WRAPCNT_EN, the wrap_cnt port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Mode 00, step 73, limit 300, burst_len 6, out_ready=1 -> 0,73,146,219,292,0; done pulses one cycle after last word; wrap_cnt=1.
REQ-033 Mode 01, seed 0, POLY 16'hB400 -> first word 1, second 16'hB400, third 16'h5A00.
REQ-034 Mode 10, limit 3, burst_len 0 -> 0,1,3,2,0,1,... until enable low; no done.
REQ-035 Mode 00, out_ready low 3 cycles after first word -> out_data held at 0, next transfer yields 73.
REQ-036 enable dropped mid-burst with start high same cycle -> IDLE next cycle, out_valid 0, done 0, out_data 0.
REQ-037 rst_l asserted mid-burst -> all outputs 0 immediately, no done after release.
